// File: rtl/dot_pkg.sv
// Shared widths, unit latency and FSM encoding for the dot-product issue controller.
package dot_pkg;
    localparam int VEC_W      = 48;
    localparam int FP_W       = 16;
    localparam int DP_LATENCY = 25;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_ISSUE = S_ISSUE,
        ST_WAIT  = S_WAIT,
        ST_HOLD  = S_HOLD
    } dot_state_e;

    typedef struct packed {
        logic [VEC_W-1:0] a;
        logic [VEC_W-1:0] b;
    } dot_pair_t;

    function automatic dot_pair_t make_pair(input logic [VEC_W-1:0] a,
                                            input logic [VEC_W-1:0] b);
        dot_pair_t p;
        p.a = a;
        p.b = b;
        return p;
    endfunction
endpackage

// File: rtl/dot_pair_fifo.sv
// DEPTH-entry synchronous FIFO of operand pairs; pointers carry an extra wrap bit
// so full and empty are told apart without a separate occupancy counter.
module dot_pair_fifo
    import dot_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  dot_pair_t push_data_i,
    input  logic      pop_i,
    output dot_pair_t head_o,
    output logic      full_o,
    output logic      empty_o
);
    localparam int AW = $clog2(DEPTH);

    dot_pair_t   mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push;
    logic        do_pop;

    assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign do_push  = push_i && !full_o;
    assign do_pop   = pop_i && !empty_o;
    assign head_o   = mem_q[rd_ptr_q[AW-1:0]];
    assign wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end
endmodule

// File: rtl/dot_issue_ctrl.sv
// Buffers operand pairs and issues them one at a time to a fixed-latency
// dot-product unit, holding each result until downstream accepts it.
// Optional timeout/err support is enabled by defining DOT_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no operation in flight; leaves as soon as a pair is buffered
// ISSUE | one-cycle dp_en pulse with the head pair on dp_vec_a/b
// WAIT  | head pair held on dp_vec_a/b until dp_valid (or timeout)
// HOLD  | captured result presented on out_product until out_ready
module dot_issue_ctrl
    import dot_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VEC_W-1:0] in_vec_a,
    input  logic [VEC_W-1:0] in_vec_b,
    output logic             dp_en,
    output logic [VEC_W-1:0] dp_vec_a,
    output logic [VEC_W-1:0] dp_vec_b,
    input  logic [FP_W-1:0]  dp_product,
    input  logic             dp_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FP_W-1:0]  out_product,
    output logic             busy
`ifdef DOT_TIMEOUT_EN
    ,
    output logic             err
`endif
);
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_cfg_check
        $error("dot_issue_ctrl: DEPTH must be a power of two >= 2 and TIMEOUT >= 2");
    end

    dot_state_e      state_q, state_d;
    logic [FP_W-1:0] out_product_q;
    dot_pair_t       head_pair;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            capture;

`ifdef DOT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             err_q, err_d;
`endif

    dot_pair_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (in_valid),
        .push_data_i(make_pair(in_vec_a, in_vec_b)),
        .pop_i      (pop),
        .head_o     (head_pair),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        capture = 1'b0;
`ifdef DOT_TIMEOUT_EN
        tmo_cnt_d = '0;
        err_d     = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef DOT_TIMEOUT_EN
                tmo_cnt_d = CNT_W'(1);
`endif
            end
            ST_WAIT: begin
                if (dp_valid) begin
                    pop     = 1'b1;
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end
`ifdef DOT_TIMEOUT_EN
                // Counter holds 0 during ISSUE, so it reaches TIMEOUT exactly
                // TIMEOUT cycles after the dp_en pulse.
                else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    pop     = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            out_product_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                out_product_q <= dp_product;
            end
        end
    end

`ifdef DOT_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign err = err_q;
`endif

    assign in_ready    = !fifo_full;
    assign dp_en       = (state_q == ST_ISSUE);
    assign dp_vec_a    = fifo_empty ? '0 : head_pair.a;
    assign dp_vec_b    = fifo_empty ? '0 : head_pair.b;
    assign out_valid   = (state_q == ST_HOLD);
    assign out_product = out_product_q;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_dot_issue_ctrl.sv
// Self-checking bench for dot_issue_ctrl with a fixed-latency dot-product model.
// Timeout checks are compiled in when DOT_TIMEOUT_EN is defined.
module tb_dot_issue_ctrl;
    import dot_pkg::*;

    localparam int DEPTH = 2;
    localparam int TMO   = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [VEC_W-1:0] in_vec_a;
    logic [VEC_W-1:0] in_vec_b;
    logic             dp_en;
    logic [VEC_W-1:0] dp_vec_a;
    logic [VEC_W-1:0] dp_vec_b;
    logic [FP_W-1:0]  dp_product;
    logic             dp_valid;
    logic             out_valid;
    logic             out_ready;
    logic [FP_W-1:0]  out_product;
    logic             busy;
`ifdef DOT_TIMEOUT_EN
    logic             err;
`endif

    logic             mdl_valid;
    logic [FP_W-1:0]  mdl_prod;
    logic             stray_valid;
    logic [FP_W-1:0]  stray_prod;
    logic             model_en;
    int               mdl_cnt;
    int               n_chk  = 0;
    int               n_pass = 0;
    int               cyc    = 0;

    always #5 clk = ~clk;

    assign dp_valid   = mdl_valid | stray_valid;
    assign dp_product = stray_valid ? stray_prod : mdl_prod;

    dot_issue_ctrl #(
        .DEPTH  (DEPTH),
        .TIMEOUT(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vec_a   (in_vec_a),
        .in_vec_b   (in_vec_b),
        .dp_en      (dp_en),
        .dp_vec_a   (dp_vec_a),
        .dp_vec_b   (dp_vec_b),
        .dp_product (dp_product),
        .dp_valid   (dp_valid),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_product(out_product),
        .busy       (busy)
`ifdef DOT_TIMEOUT_EN
        ,
        .err        (err)
`endif
    );

    typedef struct {
        logic [VEC_W-1:0] a;
        logic [VEC_W-1:0] b;
        int               stall;
        logic [FP_W-1:0]  exp;
    } vec_t;

    vec_t tbl[5];

    // Stand-in for the arithmetic: a tag the bench can predict per pair.
    function automatic logic [FP_W-1:0] prod_fn(input logic [VEC_W-1:0] a,
                                                input logic [VEC_W-1:0] b);
        if (a == 48'h3C00_4000_4200 && b == 48'h3C00_3C00_3C00) return 16'h4600;
        return a[15:0] ^ b[47:32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Dot-product model: dp_valid exactly DP_LATENCY cycles after a dp_en cycle.
    initial begin
        mdl_valid = 1'b0;
        mdl_prod  = '0;
        mdl_cnt   = 0;
        forever begin
            @(posedge clk);
            #1;
            mdl_valid = 1'b0;
            if (mdl_cnt != 0) begin
                mdl_cnt--;
                if (mdl_cnt == 0) mdl_valid = 1'b1;
            end
            if (dp_en && model_en) begin
                mdl_cnt  = DP_LATENCY;
                mdl_prod = prod_fn(dp_vec_a, dp_vec_b);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic run_table(input int n);
        int               push_idx = 0;
        int               res_idx  = 0;
        int               stall_rem;
        int               budget   = 0;
        int               en_cyc[$];
        logic [FP_W-1:0]  held = '0;
        bit               in_hold  = 0;
        bit               stable   = 1;
        bit               saw_full = 0;
        bit               extra    = 0;
        bit               fire_in, fire_out;
        stall_rem = tbl[0].stall;
        in_valid  = 1'b1;
        in_vec_a  = tbl[0].a;
        in_vec_b  = tbl[0].b;
        out_ready = 1'b0;
        while (res_idx < n && budget < 2000) begin
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            tick();
            budget++;
            if (fire_in) begin
                push_idx++;
                if (push_idx < n) begin
                    in_vec_a = tbl[push_idx].a;
                    in_vec_b = tbl[push_idx].b;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (fire_out) begin
                res_idx++;
                out_ready = 1'b0;
                if (res_idx < n) stall_rem = tbl[res_idx].stall;
            end
            if (in_valid && !in_ready) saw_full = 1;
            if (dp_en) en_cyc.push_back(cyc);
            if (out_valid && res_idx < n) begin
                if (!in_hold) begin
                    in_hold = 1;
                    held    = out_product;
                    check($sformatf("tbl_product_%0d", res_idx), out_product, tbl[res_idx].exp);
                end else if (out_product !== held) begin
                    stable = 0;
                end
                if (stall_rem > 0) begin
                    out_ready = 1'b0;
                    stall_rem--;
                end else begin
                    out_ready = 1'b1;
                end
            end else begin
                in_hold = 0;
            end
        end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (out_valid || dp_en) extra = 1;
        end
        out_ready = 1'b0;
        check("tbl_result_count", res_idx, n);
        check("tbl_hold_stable", stable, 1);
        check("tbl_in_ready_low_when_full", saw_full, 1);
        check("tbl_no_extra_results", extra, 0);
        check("tbl_dp_en_count", en_cyc.size(), n);
        if (en_cyc.size() == n) begin
            for (int i = 0; i + 1 < n; i++)
                check($sformatf("tbl_issue_interval_%0d", i), en_cyc[i+1] - en_cyc[i], 28 + tbl[i].stall);
        end
    endtask

    initial begin
        int              en_cnt, en_at, ov_at, err_at;
        logic [FP_W-1:0] ov_prod;
        logic [VEC_W-1:0] va_en, vb_en, va_wait;
        bit              bad;

        tbl[0] = '{a: 48'h1111_2222_0F0F, b: 48'hF0F0_3333_4444, stall: 0,  exp: 16'hFFFF};
        tbl[1] = '{a: 48'h0000_0000_1234, b: 48'h0001_0000_0000, stall: 0,  exp: 16'h1235};
        tbl[2] = '{a: 48'hABCD_0000_00FF, b: 48'h0F00_0000_0000, stall: 10, exp: 16'h0FFF};
        tbl[3] = '{a: 48'h3C00_4000_4200, b: 48'h3C00_3C00_3C00, stall: 3,  exp: 16'h4600};
        tbl[4] = '{a: 48'h0000_0000_8000, b: 48'h8001_5555_AAAA, stall: 0,  exp: 16'h0001};

        rst         = 1'b1;
        in_valid    = 1'b0;
        in_vec_a    = '0;
        in_vec_b    = '0;
        out_ready   = 1'b0;
        stray_valid = 1'b0;
        stray_prod  = '0;
        model_en    = 1'b1;

        // Reset values
        tick(); tick(); tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_dp_en", dp_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_product", out_product, 0);
        check("rst_busy", busy, 0);
        check("rst_dp_vec_a_empty", dp_vec_a, 0);
`ifdef DOT_TIMEOUT_EN
        check("rst_err", err, 0);
`endif
        rst = 1'b0;
        tick();

        // Stray dp_valid in IDLE
        stray_valid = 1'b1;
        stray_prod  = 16'hBEEF;
        tick();
        stray_valid = 1'b0;
        check("stray_idle_out_valid", out_valid, 0);
        check("stray_idle_out_product", out_product, 0);
        check("stray_idle_busy", busy, 0);
        tick();
        check("stray_idle_dp_en", dp_en, 0);

        // Single pair: exact latency
        in_valid = 1'b1;
        in_vec_a = 48'h3C00_4000_4200;
        in_vec_b = 48'h3C00_3C00_3C00;
        tick();
        in_valid = 1'b0;
        en_cnt = 0; en_at = -1; ov_at = -1; ov_prod = '0;
        va_en = '0; vb_en = '0; va_wait = '0;
        for (int k = 1; k <= 27; k++) begin
            tick();
            if (dp_en) begin
                en_cnt++;
                en_at = k;
                va_en = dp_vec_a;
                vb_en = dp_vec_b;
            end
            if (k == 10) va_wait = dp_vec_a;
            if (out_valid && ov_at < 0) begin
                ov_at   = k;
                ov_prod = out_product;
            end
        end
        check("single_dp_en_count", en_cnt, 1);
        check("single_dp_en_cycle", en_at, 1);
        check("single_dp_vec_a", va_en, 48'h3C00_4000_4200);
        check("single_dp_vec_b", vb_en, 48'h3C00_3C00_3C00);
        check("single_wait_dp_vec_a", va_wait, 48'h3C00_4000_4200);
        check("single_out_valid_cycle", ov_at, 27);
        check("single_out_product", ov_prod, 16'h4600);

        // Stray dp_valid in HOLD must not overwrite the held result
        stray_valid = 1'b1;
        stray_prod  = 16'hDEAD;
        tick();
        stray_valid = 1'b0;
        check("stray_hold_out_valid", out_valid, 1);
        check("stray_hold_out_product", out_product, 16'h4600);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("single_accept_out_valid", out_valid, 0);
        check("single_accept_busy", busy, 0);

        // Table-driven stream: ordering, full buffer, stalls, throughput
        run_table(5);

        // Reset in WAIT cycle 12
        in_valid = 1'b1;
        in_vec_a = tbl[0].a;
        in_vec_b = tbl[0].b;
        tick();
        in_valid = 1'b0;
        en_at = -1;
        for (int k = 0; k < 10 && en_at < 0; k++) begin
            tick();
            if (dp_en) en_at = cyc;
        end
        check("rstwait_dp_en_seen", en_at >= 0, 1);
        for (int k = 0; k < 12; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstwait_dp_en", dp_en, 0);
        check("rstwait_out_valid", out_valid, 0);
        check("rstwait_out_product", out_product, 0);
        check("rstwait_in_ready", in_ready, 1);
        check("rstwait_busy", busy, 0);
        check("rstwait_dp_vec_a", dp_vec_a, 0);
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (out_valid || dp_en || busy) bad = 1;
        end
        check("rstwait_late_dp_valid_ignored", bad, 0);
        check("rstwait_late_out_product", out_product, 0);

`ifdef DOT_TIMEOUT_EN
        // Timeout: model silent, pair dropped after TMO cycles
        model_en = 1'b0;
        in_valid = 1'b1;
        in_vec_a = tbl[1].a;
        in_vec_b = tbl[1].b;
        tick();
        in_valid = 1'b0;
        en_at = -1;
        for (int k = 0; k < 10 && en_at < 0; k++) begin
            tick();
            if (dp_en) en_at = cyc;
        end
        check("tmo_dp_en_seen", en_at >= 0, 1);
        err_at = -1;
        bad = 0;
        for (int k = 0; k < TMO + 20 && err_at < 0; k++) begin
            tick();
            if (out_valid) bad = 1;
            if (err) err_at = cyc;
        end
        check("tmo_err_delay", err_at - en_at, TMO);
        check("tmo_no_result", bad, 0);
        check("tmo_buffer_dropped", busy, 0);
        model_en = 1'b1;
        in_valid = 1'b1;
        in_vec_a = tbl[2].a;
        in_vec_b = tbl[2].b;
        tick();
        in_valid = 1'b0;
        ov_at = -1;
        for (int k = 0; k < 60 && ov_at < 0; k++) begin
            tick();
            if (out_valid) ov_at = cyc;
        end
        check("tmo_next_result_seen", ov_at >= 0, 1);
        check("tmo_next_product", out_product, tbl[2].exp);
        check("tmo_err_sticky", err, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
